// File: rtl/instr_exec.sv
// Instruction executor: accepts 8-bit instructions over valid/ready and runs them on an 8-bit accumulator.
// Optional INSTR_EXEC_FAST_MUL_EN selects a single-cycle multiplier instead of the 5-step shift-add.
module instr_exec #(
   parameter int unsigned MUL_STEPS = 5
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       ena,
   input  logic [7:0] instr_in,
   input  logic       instr_valid,
   output logic       instr_ready,
   output logic [7:0] acc_out,
   output logic       zero_flag,
   output logic       carry_flag,
   output logic       busy,
   output logic       halted,
   output logic       retire
);

   localparam int unsigned DW  = 8;
   localparam int unsigned OPW = 5;
   localparam int unsigned PW  = 13;

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SUB  = 3'b001;
   localparam logic [2:0] OP_MUL  = 3'b010;
   localparam logic [2:0] OP_AND  = 3'b011;
   localparam logic [2:0] OP_OR   = 3'b100;
   localparam logic [2:0] OP_XOR  = 3'b101;
   localparam logic [2:0] OP_LDI  = 3'b110;
   localparam logic [2:0] OP_HALT = 3'b111;

   typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_HALT} state_t;

   state_t          r_state;
   logic [DW-1:0]   r_acc;
   logic            r_zero;
   logic            r_carry;
   logic            r_retire;

   logic [2:0]      w_opcode;
   logic [DW-1:0]   w_op8;
   logic [DW-1:0]   w_res;
   logic            w_res_carry;

   assign w_opcode = instr_in[7:5];
   assign w_op8    = DW'(instr_in[OPW-1:0]);

`ifdef INSTR_EXEC_FAST_MUL_EN
   logic [PW-1:0]   w_fast_prod;
   assign w_fast_prod = PW'(r_acc) * PW'(instr_in[OPW-1:0]);
`else
   localparam int unsigned SW = 3;
   logic [PW-1:0]   r_mcand;
   logic [OPW-1:0]  r_mplier;
   logic [PW-1:0]   r_prod;
   logic [SW-1:0]   r_step;
   logic [PW-1:0]   w_mul_sum;
   logic            w_last;

   // Shift-add: multiplicand shifts left while multiplier bits are consumed LSB first
   assign w_mul_sum = r_prod + (r_mplier[0] ? r_mcand : PW'(0));
   assign w_last    = (r_step == SW'(MUL_STEPS - 1));
`endif

   // Single-cycle datapath result for the instruction on instr_in
   always_comb begin
      w_res       = r_acc;
      w_res_carry = 1'b0;
      case (w_opcode)
         OP_ADD:  {w_res_carry, w_res} = {1'b0, r_acc} + {1'b0, w_op8};
         OP_SUB:  {w_res_carry, w_res} = {1'b0, r_acc} - {1'b0, w_op8};
         OP_AND:  w_res = r_acc & w_op8;
         OP_OR:   w_res = r_acc | w_op8;
         OP_XOR:  w_res = r_acc ^ w_op8;
         OP_LDI:  w_res = w_op8;
`ifdef INSTR_EXEC_FAST_MUL_EN
         OP_MUL: begin
            w_res       = w_fast_prod[DW-1:0];
            w_res_carry = |w_fast_prod[PW-1:DW];
         end
`endif
         default: begin
            w_res       = r_acc;
            w_res_carry = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= ST_IDLE;
         r_acc    <= '0;
         r_zero   <= 1'b1;
         r_carry  <= 1'b0;
         r_retire <= 1'b0;
`ifndef INSTR_EXEC_FAST_MUL_EN
         r_mcand  <= '0;
         r_mplier <= '0;
         r_prod   <= '0;
         r_step   <= '0;
`endif
      end else if (!ena) begin
         r_retire <= 1'b0;
      end else begin
         r_retire <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (instr_valid) begin
                  if (w_opcode == OP_HALT) begin
                     r_state  <= ST_HALT;
                     r_retire <= 1'b1;
                  end
`ifndef INSTR_EXEC_FAST_MUL_EN
                  else if (w_opcode == OP_MUL) begin
                     r_state  <= ST_MUL;
                     r_mcand  <= PW'(r_acc);
                     r_mplier <= instr_in[OPW-1:0];
                     r_prod   <= '0;
                     r_step   <= '0;
                  end
`endif
                  else begin
                     r_acc    <= w_res;
                     r_carry  <= w_res_carry;
                     r_zero   <= (w_res == '0);
                     r_retire <= 1'b1;
                  end
               end
            end
            ST_MUL: begin
`ifndef INSTR_EXEC_FAST_MUL_EN
               r_prod   <= w_mul_sum;
               r_mcand  <= r_mcand << 1;
               r_mplier <= r_mplier >> 1;
               r_step   <= r_step + SW'(1);
               if (w_last) begin
                  r_acc    <= w_mul_sum[DW-1:0];
                  r_carry  <= |w_mul_sum[PW-1:DW];
                  r_zero   <= (w_mul_sum[DW-1:0] == '0);
                  r_retire <= 1'b1;
                  r_state  <= ST_IDLE;
               end
`else
               r_state <= ST_IDLE;
`endif
            end
            ST_HALT: r_state <= ST_HALT;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign instr_ready = ena & (r_state == ST_IDLE);
   assign busy        = (r_state != ST_IDLE);
   assign halted      = (r_state == ST_HALT);
   assign acc_out     = r_acc;
   assign zero_flag   = r_zero;
   assign carry_flag  = r_carry;
   assign retire      = r_retire;

endmodule

// File: doc/instr_exec.md
Name: instr_exec

Overview:
- Instruction consumer for the mode-1 CPU path; the receiving end of the 8-bit instruction stream from the program-counter/ROM block.
- Accepts instructions over a valid/ready handshake, decodes opcode[7:5] and operand[4:0], and executes them on an 8-bit accumulator.
- Drives accumulator and flag status to the top level.

Parameters:
MUL_STEPS, 5, iterations of the iterative multiplier (one per operand bit); fixed at 5 to match the operand width.

Ports:
clock  input  1  system clock, rising edge
reset_n  input  1  asynchronous reset, active-low
ena  input  1  global enable; when low, all state, counters and outputs hold
instr_in  input  8  instruction: [7:5] opcode, [4:0] operand
instr_valid  input  1  instr_in holds a valid instruction
instr_ready  output  1  block can accept an instruction this cycle
acc_out  output  8  accumulator value
zero_flag  output  1  accumulator equals zero after the last write
carry_flag  output  1  carry/borrow/overflow of the last arithmetic op
busy  output  1  state is not IDLE
halted  output  1  HALT executed
retire  output  1  one-cycle pulse, cycle after an instruction completes

Behaviour:
- Clock is `clock`. Reset is asynchronous and active-low on `reset_n`.
- Reset values: acc_out=0x00, zero_flag=1, carry_flag=0, busy=0, halted=0, retire=0, state=IDLE.
- instr_ready = ena & (state==IDLE). An instruction is accepted on a rising edge where instr_valid & instr_ready.
- The operand is zero-extended to 8 bits (op8). All results are truncated to 8 bits.
- Opcodes:
  - 000 ADD: acc <= acc+op8; carry = bit 8 of the sum. 0x00 (ADD 0) therefore acts as NOP: acc unchanged, carry cleared.
  - 001 SUB: acc <= acc-op8; carry = 1 iff acc<op8 (borrow).
  - 010 MUL: acc <= low 8 bits of acc*op8; carry = 1 iff the 13-bit product is >255.
  - 011 AND, 100 OR, 101 XOR with op8: carry <= 0.
  - 110 LDI: acc <= op8; carry <= 0.
  - 111 HALT: acc and flags unchanged.
- zero_flag is updated on every acc write and reflects the new acc.
- FSM states: IDLE, MUL, HALT.
  - IDLE: single-cycle ops (all except MUL and HALT) write acc and flags on the accepting edge and stay in IDLE, giving back-to-back throughput of 1 per cycle.
  - IDLE -> MUL on accepting MUL: latch the multiplicand (acc) and multiplier (operand) and clear the 13-bit partial product.
  - MUL: shift-add one operand bit per edge, LSB first, over MUL_STEPS edges. On the last step, write acc and carry, then go to IDLE. If accepted at edge N, acc updates at edge N+5 and instr_ready is low from after edge N until after edge N+5.
  - IDLE -> HALT on accepting HALT. HALT is absorbing: instr_ready=0, halted=1. Exit only by reset.
- retire: registered. High for exactly the one cycle following the edge that completes an instruction; for HALT this is the accepting edge.
- ena low: no acceptance; MUL iteration freezes mid-step and resumes when ena returns; retire is forced low.
- Reset asserted mid-MUL: the operation is aborted and all outputs return to reset values immediately (asynchronously).
- instr_valid is ignored while instr_ready=0. Upstream must hold instr_in stable while valid & !ready.

Optional Feature:
- Macro: INSTR_EXEC_FAST_MUL_EN.
- Defined: MUL is single-cycle using a combinational 8x5 multiplier. It writes acc and carry on the accepting edge, the MUL state is unused, and instr_ready stays high.
- Undefined: iterative 5-step shift-add as described in Behaviour (minimum area).
- Results and flags are identical in both builds; only latency differs.

Test Plan:
- Reset, then stream 0x03, 0x22, 0x45, 0x00 with valid held high -> acc 0x03, then 0x01, then 0x05, then 0x05; the MUL holds ready low for 5 cycles (0 cycles with fast MUL); four retire pulses.
- LDI 31 (0xDF), then MUL 31 (0x5F) -> acc=0xC1 (961 mod 256), carry=1, zero=0.
- Reset, then SUB 2 (0x22) -> acc=0xFE, carry=1. Then ADD 2 (0x02) -> acc=0x00, carry=1, zero=1.
- LDI 0x0F, AND 0x03, OR 0x10, XOR 0x1F -> acc 0x0F, 0x03, 0x13, 0x0C; carry=0 throughout.
- LDI 3, MUL 5, drop ena for 3 cycles after the 2nd MUL step -> completion delayed exactly 3 cycles, acc=0x0F; no retire pulse while ena is low.
- HALT (0xE0), then offer 0x01 -> halted=1, ready=0, acc unchanged. Assert reset_n low mid-MUL in a separate run -> acc=0x00, busy=0 without a clock edge.
